pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits; WIDTH >= 1.
REQ-002 SHALL have parameter NUM_STAGES, default 4: number of carry-split pipeline stages; WIDTH % NUM_STAGES == 0 is required; elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand transfer request.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands this cycle.
REQ-007 SHALL have port op, input, adder_pkg::op_e: OP_ADD or OP_SUB.
REQ-008 SHALL have port in0, input, WIDTH bits: first operand.
REQ-009 SHALL have port in1, input, WIDTH bits: second operand.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-012 SHALL have port sum, output, WIDTH bits: result modulo 2^WIDTH.
REQ-013 SHALL have port carry_out, output, 1 bit: raw carry out of MSB (for SUB: 1 = no borrow).
REQ-014 SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL accept operands on a cycle where in_valid && in_ready; SHALL compute in0 + in1 for OP_ADD and in0 + ~in1 + 1 for OP_SUB.
REQ-016 SHALL split operands into NUM_STAGES chunks of WIDTH/NUM_STAGES bits; stage k SHALL add chunk k (LSB chunk first) with the registered carry from stage k-1; higher chunks and op SHALL be delay-registered (skewed) alongside.
REQ-017 SHALL present the result with out_valid high exactly NUM_STAGES cycles after acceptance when no stall occurs.
REQ-018 SHALL sustain one accepted operation per cycle when out_ready is held high.
REQ-019 in_ready SHALL equal !out_valid || out_ready (global pipeline enable); when low, every stage register including valid bits SHALL hold.
REQ-020 sum, carry_out, overflow SHALL remain stable while out_valid && !out_ready.
REQ-021 overflow SHALL be computed from the MSB carry-in and carry-out of the final chunk (XOR); it SHALL be valid whenever out_valid is high.
REQ-022 Bubbles (in_valid low on an enabled cycle) SHALL propagate as out_valid low; no result SHALL be duplicated or dropped.
REQ-023 For NUM_STAGES == 1 the block SHALL degenerate to a single registered full-width adder with latency 1.

Reset
REQ-024 When rst_n is low at a rising clk edge, all stage valid bits and out_valid SHALL clear to 0; sum, carry_out, overflow SHALL clear to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight results; in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-026 Datapath registers other than the output stage need not be reset.

Structure
REQ-027 Package adder_pkg SHALL hold typedef op_e (OP_ADD=0, OP_SUB=1) and a function computing chunk width.
REQ-028 Sub-module adder_slice SHALL implement one chunk: CHUNK-bit operands plus carry-in, producing CHUNK-bit sum, carry-out and MSB carry-in; one instance per stage via generate.

Verification (WIDTH=16, NUM_STAGES=4)
REQ-029 ADD 0xFFFF + 0x0001, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0000, carry_out=1, overflow=0.
REQ-030 SUB 0x0000 - 0x0001 -> sum=0xFFFF, carry_out=0, overflow=0; ADD 0x7FFF + 0x0001 -> sum=0x8000, overflow=1; SUB 0x8000 - 0x0001 -> sum=0x7FFF, overflow=1.
REQ-031 Back-to-back 8 ADDs (i + 0x0100*i, i=0..7), out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, results in order, correct.
REQ-032 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen at the same value; on out_ready=1 remaining results drain in order, none lost.
REQ-033 rst_n low for 1 cycle with 3 operations in flight -> out_valid=0, sum=0 afterwards, no stale result ever appears; next accepted op produces result after 4 cycles.
REQ-034 Random op/operands over 10k transactions with random in_valid/out_ready against a reference model -> zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: op encoding and chunk-width helper shared by the pipelined adder
package adder_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: one CHUNK-bit ripple chunk (a, b, cin -> s, cout, msb_cin)
module adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             msb_cin
);
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    msb_cin = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: NUM_STAGES carry-split add/sub pipeline (valid/ready in, sum/carry_out/overflow out)
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = chunk_width(WIDTH, NUM_STAGES);
  if (WIDTH < 1 || NUM_STAGES < 1 || WIDTH % NUM_STAGES != 0) begin : g_bad
    $error("pipelined_adder: WIDTH must be a positive multiple of NUM_STAGES");
  end
  logic             en;
  logic [WIDTH-1:0] ia [NUM_STAGES];
  logic [WIDTH-1:0] ib [NUM_STAGES];
  logic             ic [NUM_STAGES];
  logic [CW-1:0]    ss [NUM_STAGES];
  logic             sc [NUM_STAGES];
  logic             sm [NUM_STAGES];
  logic [WIDTH-1:0] a_d [NUM_STAGES];
  logic [WIDTH-1:0] a_q [NUM_STAGES];
  logic [WIDTH-1:0] b_d [NUM_STAGES];
  logic [WIDTH-1:0] b_q [NUM_STAGES];
  logic [WIDTH-1:0] s_d [NUM_STAGES];
  logic [WIDTH-1:0] s_q [NUM_STAGES];
  logic             v_d [NUM_STAGES];
  logic             v_q [NUM_STAGES];
  logic             c_d [NUM_STAGES];
  logic             c_q [NUM_STAGES];
  logic             m_d, m_q;
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_st
    adder_slice #(.CHUNK(CW)) u_slice (
      .a      (ia[k][k*CW +: CW]),
      .b      (ib[k][k*CW +: CW]),
      .cin    (ic[k]),
      .s      (ss[k]),
      .cout   (sc[k]),
      .msb_cin(sm[k])
    );
  end
  // subtraction folds into stage 0: b is inverted once and the +1 enters as carry-in
  always_comb begin
    en        = !v_q[NUM_STAGES-1] || out_ready;
    in_ready  = en;
    out_valid = v_q[NUM_STAGES-1];
    sum       = s_q[NUM_STAGES-1];
    carry_out = c_q[NUM_STAGES-1];
    overflow  = c_q[NUM_STAGES-1] ^ m_q;
    ia[0]     = in0;
    ib[0]     = (op == OP_SUB) ? ~in1 : in1;
    ic[0]     = (op == OP_SUB);
    for (int k = 1; k < NUM_STAGES; k++) begin
      ia[k] = a_q[k-1];
      ib[k] = b_q[k-1];
      ic[k] = c_q[k-1];
    end
  end
  always_comb begin
    s_d[0] = '0;
    v_d[0] = in_valid;
    for (int k = 1; k < NUM_STAGES; k++) begin
      s_d[k] = s_q[k-1];
      v_d[k] = v_q[k-1];
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      a_d[k]              = ia[k];
      b_d[k]              = ib[k];
      c_d[k]              = sc[k];
      s_d[k][k*CW +: CW]  = ss[k];
    end
    m_d = sm[NUM_STAGES-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      m_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      m_q <= m_d;
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomized checks of pipelined_adder against a behavioural model
module tb_pipelined_adder;
  import adder_pkg::*;
  typedef struct packed {logic [15:0] s; logic c; logic o;} res_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  op_e         op = OP_ADD;
  logic [15:0] in0 = '0;
  logic [15:0] in1 = '0;
  logic        in_ready, out_valid, carry_out, overflow;
  logic [15:0] sum;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  pipelined_adder #(.WIDTH(16), .NUM_STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );
  function automatic res_t model(input logic o, input logic [15:0] x, input logic [15:0] y);
    res_t r;
    logic [16:0] u;
    int sx, sy, t;
    u = o ? {1'b0, x} + {1'b0, ~y} + 17'd1 : {1'b0, x} + {1'b0, y};
    sx = $signed(x);
    sy = $signed(y);
    t = o ? sx - sy : sx + sy;
    r.s = u[15:0];
    r.c = u[16];
    r.o = (t > 32767) || (t < -32768);
    return r;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    step;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if ({sum, carry_out, overflow} !== 18'h0) begin errors++; $display("FAIL reset_outputs: got %h/%b/%b want 0", sum, carry_out, overflow); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step;
  endtask
  task automatic test_directed;
    logic        to [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] ta [4] = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
    logic [15:0] tb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    logic [15:0] ts [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic        tc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        tv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      op = op_e'(to[i]);
      in0 = ta[i];
      in1 = tb[i];
      out_ready = 1'b1;
      step;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        step;
        lat++;
      end
      checks++;
      if (lat != 4) begin errors++; $display("FAIL directed%0d_latency: got %0d want 4", i, lat); end
      checks++;
      if (sum !== ts[i]) begin errors++; $display("FAIL directed%0d_sum: got %h want %h", i, sum, ts[i]); end
      checks++;
      if (carry_out !== tc[i]) begin errors++; $display("FAIL directed%0d_carry: got %b want %b", i, carry_out, tc[i]); end
      checks++;
      if (overflow !== tv[i]) begin errors++; $display("FAIL directed%0d_overflow: got %b want %b", i, overflow, tv[i]); end
      step;
    end
  endtask
  task automatic test_back_to_back;
    logic want_v;
    logic [15:0] want_s;
    out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      want_v = (t >= 4) && (t < 12);
      want_s = 16'(257 * (t - 4));
      checks++;
      if (out_valid !== want_v) begin errors++; $display("FAIL b2b_valid_c%0d: got %b want %b", t, out_valid, want_v); end
      if (want_v) begin
        checks++;
        if ({sum, carry_out, overflow} !== {want_s, 2'b00}) begin
          errors++; $display("FAIL b2b_result_c%0d: got %h/%b/%b want %h/0/0", t, sum, carry_out, overflow, want_s);
        end
      end
      in_valid = (t < 8);
      op = OP_ADD;
      in0 = 16'(t);
      in1 = 16'(256 * t);
      #1;
      if (t < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_c%0d: got %b want 1", t, in_ready); end
      end
      step;
    end
    in_valid = 1'b0;
  endtask
  task automatic test_stall;
    res_t exp [5];
    int sent = 0;
    int got = 0;
    for (int i = 0; i < 5; i++) exp[i] = model(1'b0, 16'(4096 * (i + 1)), 16'(i + 1));
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      out_ready = (cyc >= 7);
      in_valid = (sent < 5);
      op = OP_ADD;
      in0 = 16'(4096 * (sent + 1));
      in1 = 16'(sent + 1);
      #1;
      if (cyc < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_fill_ready_c%0d: got %b want 1", cyc, in_ready); end
      end else if (cyc < 7) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_c%0d: got %b want 0", cyc, in_ready); end
        checks++;
        if (out_valid !== 1'b1 || {sum, carry_out, overflow} !== exp[0]) begin
          errors++; $display("FAIL stall_frozen_c%0d: got %b %h/%b/%b want 1 %h", cyc, out_valid, sum, carry_out, overflow, exp[0]);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if ({sum, carry_out, overflow} !== exp[got]) begin
          errors++; $display("FAIL stall_drain%0d: got %h/%b/%b want %h", got, sum, carry_out, overflow, exp[got]);
        end
        got++;
      end
      step;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5 || sent != 5) begin errors++; $display("FAIL stall_count: got %0d sent %0d want 5 5", got, sent); end
  endtask
  task automatic test_reset_mid;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op = OP_ADD;
      in0 = 16'(256 + i);
      in1 = 16'(i);
      step;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0) begin errors++; $display("FAIL rstmid_outputs: got %b %h want 0 0000", out_valid, sum); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      step;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_c%0d: got %b want 0", i, out_valid); end
    end
    in_valid = 1'b1;
    op = OP_SUB;
    in0 = 16'h0005;
    in1 = 16'h0007;
    step;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step;
      lat++;
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL rstmid_latency: got %0d want 4", lat); end
    checks++;
    if ({sum, carry_out, overflow} !== {16'hFFFE, 2'b00}) begin
      errors++; $display("FAIL rstmid_result: got %h/%b/%b want fffe/0/0", sum, carry_out, overflow);
    end
    step;
  endtask
  task automatic test_random;
    res_t q[$];
    res_t e;
    logic [17:0] prev = '0;
    logic stalled = 1'b0;
    int acc = 0;
    int cycles = 0;
    while (acc < 10000 && cycles < 60000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      op = op_e'($urandom_range(0, 1));
      in0 = 16'($urandom);
      in1 = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rand_in_ready_c%0d: got %b", cycles, in_ready); end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || {sum, carry_out, overflow} !== prev) begin
          errors++; $display("FAIL rand_hold_c%0d: got %b %h want 1 %h", cycles, out_valid, {sum, carry_out, overflow}, prev);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(op, in0, in1));
        acc++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious_c%0d: got result %h want none", cycles, sum);
        end else begin
          e = q.pop_front();
          if ({sum, carry_out, overflow} !== e) begin
            errors++; $display("FAIL rand_result_c%0d: got %h/%b/%b want %h/%b/%b", cycles, sum, carry_out, overflow, e.s, e.c, e.o);
          end
        end
      end
      stalled = out_valid && !out_ready;
      prev = {sum, carry_out, overflow};
      step;
      cycles++;
    end
    checks++;
    if (acc != 10000) begin errors++; $display("FAIL rand_accepted: got %0d want 10000", acc); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_drain_spurious: got %h want none", sum);
        end else begin
          e = q.pop_front();
          if ({sum, carry_out, overflow} !== e) begin
            errors++; $display("FAIL rand_drain: got %h/%b/%b want %h/%b/%b", sum, carry_out, overflow, e.s, e.c, e.o);
          end
        end
      end
      step;
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d pending want 0", q.size()); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
